framebuffer_reader: RTL

FRAMEBUFFER_READER -- requirements
Module: framebuffer_reader

---
 rtl/framebuffer_reader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/framebuffer_reader.sv
// Scans a frame buffer into a small pixel FIFO using credit-based read flow control.
// Optional FB_RESYNC_EN: adds frame_sync, which flushes the FIFO and restarts the scan at address 0.
module framebuffer_reader #(
    parameter int ADDR_MAX   = 19661,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_2M,
    input  logic        rst_n,
    input  logic        enable,
    output logic [15:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [15:0] mem_rd_data,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eof,
    output logic        busy,
    output logic [7:0]  frame_cnt
`ifdef FB_RESYNC_EN
    ,
    input  logic        frame_sync
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [15:0] AMAX = 16'(ADDR_MAX);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    typedef struct packed {
        logic [15:0] data;
        logic        sof;
        logic        eof;
    } pix_t;

    state_t          state_q, state_d;
    logic [15:0]     addr_q, addr_d;
    logic            rd_en_q, rd_en_d;
    logic            pend_q, pend_d;
    logic            pend_sof_q, pend_sof_d;
    logic            pend_eof_q, pend_eof_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      frame_q, frame_d;
    pix_t            fifo_q [FIFO_DEPTH];
    pix_t            head;
    logic            push, pop, resync, last_rd, not_empty;
    logic [CW+1:0]   credit;

`ifdef FB_RESYNC_EN
    assign resync = frame_sync && (state_q == RUN);
`else
    assign resync = 1'b0;
`endif

    always_comb begin
        head      = fifo_q[rd_ptr_q];
        not_empty = (cnt_q != '0);
        push      = pend_q && !resync;
        pop       = not_empty && pix_ready && !resync;
        last_rd   = rd_en_q && (addr_q == AMAX);
        // Reads already issued or returning count against FIFO space, so the FIFO can never overflow.
        credit    = (CW+2)'(cnt_q) + (CW+2)'(rd_en_q) + (CW+2)'(pend_q);

        state_d    = state_q;
        addr_d     = addr_q;
        rd_en_d    = 1'b0;
        pend_d     = rd_en_q;
        pend_sof_d = (addr_q == 16'd0);
        pend_eof_d = (addr_q == AMAX);
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d      = cnt_q + CW'(push) - CW'(pop);
        frame_d    = (pop && head.eof) ? frame_q + 8'd1 : frame_q;

        if (rd_en_q)
            addr_d = last_rd ? 16'd0 : addr_q + 16'd1;

        case (state_q)
            IDLE: begin
                addr_d = 16'd0;
                if (enable)
                    state_d = RUN;
            end
            RUN: begin
                if (last_rd && !enable)
                    state_d = DRAIN;
                else
                    rd_en_d = (credit < (CW+2)'(FIFO_DEPTH));
            end
            DRAIN: begin
                if (!not_empty && !pend_q && !rd_en_q)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (resync) begin
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            pend_d   = 1'b0;
            rd_en_d  = 1'b0;
            addr_d   = 16'd0;
        end
    end

    always_ff @(posedge clk_2M) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= 16'd0;
            rd_en_q    <= 1'b0;
            pend_q     <= 1'b0;
            pend_sof_q <= 1'b0;
            pend_eof_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            frame_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_en_q    <= rd_en_d;
            pend_q     <= pend_d;
            pend_sof_q <= pend_sof_d;
            pend_eof_q <= pend_eof_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            frame_q    <= frame_d;
        end
    end

    always_ff @(posedge clk_2M) begin
        if (push)
            fifo_q[wr_ptr_q] <= '{data: mem_rd_data, sof: pend_sof_q, eof: pend_eof_q};
    end

    // Head fields are gated so an empty FIFO presents zeros instead of stale storage.
    assign mem_addr  = addr_q;
    assign mem_rd_en = rd_en_q;
    assign pix_valid = not_empty;
    assign pix_data  = not_empty ? head.data : 16'd0;
    assign pix_sof   = not_empty && head.sof;
    assign pix_eof   = not_empty && head.eof;
    assign busy      = (state_q != IDLE) || not_empty;
    assign frame_cnt = frame_q;

endmodule
